add_seq_ctrl: RTL
=================

# add_seq_ctrl

Sequencing stage wrapped around the 4-bit combinational ripple adder. It accepts operand pairs on a valid/ready handshake and registers them onto the adder's term inputs. It then waits a programmable settle time, captures the adder's 5-bit result into a 2-entry output buffer, and presents results downstream on a second valid/ready handshake. It also keeps a saturating count of carry-out (overflow) events.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles operands are held on the adder before the result is sampled; legal range 1..15.
- CNT_W, 8, width of the overflow counter.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream operand pair valid.
- i_term1  in  4  operand A.
- i_term2  in  4  operand B.
- o_ready  out  1  stage can accept an operand pair this cycle.
- o_add_term1  out  4  registered operand A to adder.
- o_add_term2  out  4  registered operand B to adder.
- i_add_result  in  5  adder result {carry, sum[3:0]}.
- o_valid  out  1  result available at buffer head.
- o_result  out  5  buffer head result.
- i_ready  in  1  downstream accepts result.
- o_ovf_cnt  out  CNT_W  saturating count of captured results with bit 4 set.

## Operation
- FSM has two states:
  - IDLE: o_ready = (buffer occupancy + 0) < 2.
  - DRIVE: o_ready = 0.
- Accept: when i_valid && o_ready at an edge, load i_term1/i_term2 into the operand registers, clear the settle counter, and go to DRIVE.
- DRIVE: the settle counter increments each edge. On the edge where the counter reaches SETTLE_CYCLES-1, push i_add_result into the buffer, increment o_ovf_cnt if i_add_result[4]=1, and return to IDLE.
- Operand registers hold their last value in IDLE. They change only on accept.
- Buffer space is reserved at accept, because o_ready requires a free entry. A push therefore never finds the buffer full.
- Output: o_valid = buffer not empty. o_result = head entry. Pop on i_valid… no: pop when o_valid && i_ready at an edge.
- Simultaneous push and pop in one edge are both performed; occupancy is unchanged.
- When no pop occurs, o_result is held stable while o_valid=1.
- o_ovf_cnt saturates at 2^CNT_W-1 and never wraps.
- No arithmetic is done here; the 5-bit result is passed through unmodified.
- Reset values: state IDLE, o_add_term1=0, o_add_term2=0, buffer empty (o_valid=0, o_result=0), o_ovf_cnt=0. With an empty buffer, o_ready=1 in the first cycle after reset.
- Reset mid-operation: any in-flight pair and all buffered results are discarded. No partial push occurs.
- Input contract: i_valid without o_ready is legal. Upstream must hold i_term1/i_term2 stable until the transfer occurs.

## Timing
- Accept at edge E0.
- The adder sees the new operands from E0 onward.
- The result is pushed at edge E0+SETTLE_CYCLES. o_valid rises in the cycle after that edge if the buffer was empty.
- Peak throughput: one operand pair per SETTLE_CYCLES+1 cycles, because o_ready is low during DRIVE and re-asserts in IDLE.
- o_ready is combinational from state and occupancy only. It does not depend on i_valid.
- o_valid and o_result are registered outputs. There is no combinational path from i_ready to any output except via buffer state after the edge.
- Backpressure: with i_ready=0, two results fill the buffer and o_ready then stays low. One pop frees an entry, and o_ready rises in the following cycle.

## Structure
- Shared package add_seq_pkg holds:
  - DATA_W=4, RES_W=5.
  - The state enum {ST_IDLE, ST_DRIVE}.
  - The buffer depth constant BUF_DEPTH=2.
- Sub-module add_result_fifo: 2-entry, RES_W-wide synchronous FIFO with push/pop/full/empty/count and asynchronous active-high reset. add_seq_ctrl instantiates it once.
- The adder itself is instantiated alongside this block by the parent, not inside it.

## Test plan
- Single op: reset, SETTLE_CYCLES=1, send 4'h3 + 4'h4 with i_ready=1 → o_result=5'h07 with o_valid one cycle after push; o_ovf_cnt=0.
- Overflow: send 4'hF + 4'h1, then 4'hF + 4'hF → results 5'h10, 5'h1E; o_ovf_cnt=2.
- Backpressure: i_ready=0, offer three pairs (1+1, 2+2, 3+3) → two accepted, o_ready held 0; release i_ready → 5'h02, 5'h04 popped in order, then third pair accepted and yields 5'h06.
- Settle: SETTLE_CYCLES=3, send 4'h9 + 4'h8 → push occurs exactly 3 edges after accept; result 5'h11; o_ready low for 3 cycles.
- Reset mid-op: accept 4'h7 + 4'h7, assert i_rst during DRIVE → o_valid stays 0, o_add_term1/2=0, o_ovf_cnt=0, o_ready=1 after release.
- Saturation: CNT_W=2, six carry-producing ops → o_ovf_cnt sticks at 3.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the adder sequencing stage and its result buffer.
package add_seq_pkg;
  localparam int DATA_W    = 4;
  localparam int RES_W     = 5;
  localparam int BUF_DEPTH = 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_DRIVE
  } state_t;
endpackage

// File: rtl/add_result_fifo.sv
// Small synchronous FIFO holding captured adder results until downstream takes them.
module add_result_fifo
  import add_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [RES_W-1:0] i_data,
  input  logic             i_pop,
  output logic [RES_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [OCC_W-1:0] o_count
);
  logic [RES_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count == OCC_W'(BUF_DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
  end
endmodule

// File: rtl/add_seq_ctrl.sv
// Registers operand pairs onto an external ripple adder, waits for it to settle,
// buffers the result and counts carry-out events.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_term1,
  input  logic [DATA_W-1:0] i_term2,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_add_term1,
  output logic [DATA_W-1:0] o_add_term2,
  input  logic [RES_W-1:0]  i_add_result,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_ovf_cnt
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       settle_cnt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        // A free entry must exist before accepting so the later push cannot overflow.
        o_ready = (fifo_count < OCC_W'(BUF_DEPTH));
        if (i_valid && o_ready) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept  = i_valid && o_ready;
  assign o_valid = !fifo_empty;
  assign pop     = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_add_term1 <= '0;
      o_add_term2 <= '0;
      settle_cnt  <= '0;
    end else if (accept) begin
      o_add_term1 <= i_term1;
      o_add_term2 <= i_term2;
      settle_cnt  <= '0;
    end else if (state == ST_DRIVE) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        o_ovf_cnt <= '0;
    else if (push && i_add_result[4]) o_ovf_cnt <= sat_inc(o_ovf_cnt);
  end

  always @(posedge i_clk) begin
    if (!i_rst) assert (!(push && fifo_full));
  end

  add_result_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (i_add_result),
    .i_pop   (pop),
    .o_data  (o_result),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );
endmodule
